// File: rtl/pwm_adc.sv
// pwm_adc: recovers the WIDTH-bit code from a 1-bit PWM stream produced by the
// matching PWM DAC. One DAC frame is 2^WIDTH clocks and carries code+1 high
// samples starting at sample k=0. This block aligns to the frame on a rising
// edge, counts the high samples and reports code = highs-1.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   enable  in   1 = measure; 0 = drop alignment and hold out
//   pwm_in  in   PWM stream, may be asynchronous to clk
//   out     out  last decoded code
//   valid   out  one-cycle pulse when out updates
//   locked  out  frame alignment confirmed by a completed frame
//   err     out  one-cycle pulse on a framing error
//
// state   | meaning
// HUNT    | waiting for a rising edge to define sample k=0
// MEASURE | aligned; phase is the sample index within the frame

module pwm_adc #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2   // legal range 1..3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             locked,
  output logic             err
);

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] PHASE_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] PHASE_LAST = '1;
  localparam logic [WIDTH:0]   CNT_ONE    = {{WIDTH{1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_d_q;
  logic [WIDTH-1:0]       phase_q, phase_d;
  logic [WIDTH:0]         hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0]       out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   err_q, err_d;

  logic                   pwm_s;
  logic                   pwm_rise;
  logic [WIDTH:0]         total;
  logic [WIDTH:0]         total_m1;

  assign pwm_s    = sync_q[SYNC_STAGES-1];
  assign pwm_rise = pwm_s & ~pwm_d_q;
  // Total includes the last sample of the frame, which is not yet in hi_cnt.
  assign total    = hi_cnt_q + {{WIDTH{1'b0}}, pwm_s};
  assign total_m1 = total - CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      sync_q   <= '0;
      pwm_d_q  <= 1'b0;
      phase_q  <= '0;
      hi_cnt_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync_q[0] <= pwm_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      pwm_d_q  <= pwm_s;
      state_q  <= state_d;
      phase_q  <= phase_d;
      hi_cnt_q <= hi_cnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    hi_cnt_d = hi_cnt_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;

    if (!enable) begin
      state_d  = ST_HUNT;
      phase_d  = '0;
      hi_cnt_d = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          locked_d = 1'b0;
          phase_d  = '0;
          hi_cnt_d = '0;
          // The edge cycle itself is sample k=0 and is high.
          if (pwm_rise) begin
            state_d  = ST_MEASURE;
            phase_d  = PHASE_ONE;
            hi_cnt_d = CNT_ONE;
          end
        end
        ST_MEASURE: begin
          if (phase_q != '0 && pwm_rise) begin
            // Unexpected edge: treat it as the new k=0 and stay measuring.
            err_d    = 1'b1;
            locked_d = 1'b0;
            phase_d  = PHASE_ONE;
            hi_cnt_d = CNT_ONE;
          end else if (phase_q == '0 && !pwm_s) begin
            // Every frame starts high; a low k=0 means alignment is gone.
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = ST_HUNT;
            phase_d  = '0;
            hi_cnt_d = '0;
          end else if (phase_q == '0) begin
            phase_d  = PHASE_ONE;
            hi_cnt_d = CNT_ONE;
          end else begin
            phase_d  = phase_q + PHASE_ONE;
            hi_cnt_d = total;
            if (phase_q == PHASE_LAST) begin
              out_d    = total_m1[WIDTH-1:0];
              valid_d  = 1'b1;
              locked_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  assign out    = out_q;
  assign valid  = valid_q;
  assign locked = locked_q;
  assign err    = err_q;

endmodule

// File: tb/tb_pwm_adc.sv
module tb_pwm_adc;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int FL = 1 << W;

  logic         clk = 1'b0;
  logic         rst, enable, pwm_in;
  logic [W-1:0] out;
  logic         valid, locked, err;

  pwm_adc #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pwm_in(pwm_in),
    .out(out), .valid(valid), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dac_k = 0;

  // Reference model: frame alignment is an absolute start cycle, the code is
  // the count of high samples over the 2^W-sample window ending at k=2^W-1.
  logic         m_sync [SS];
  logic         m_pd;
  bit           m_hunt;
  int           m_start;
  logic [W-1:0] m_out;
  logic         m_valid, m_locked, m_err;
  bit           s_hist [65536];

  // Observed outputs per cycle: {valid, err, locked, out}.
  logic [10:0]  obs [65536];

  typedef struct {
    int           code;
    logic [W-1:0] exp_out;
  } vec_t;
  vec_t tbl [7];
  int   fs  [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic s, e;
    int   k, sum;
    if (rst) begin
      for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
      m_pd = 1'b0; m_hunt = 1'b1; m_out = '0;
      m_valid = 1'b0; m_locked = 1'b0; m_err = 1'b0;
    end else begin
      s = m_sync[SS-1];
      e = s & ~m_pd;
      s_hist[cyc] = s;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (!enable) begin
        m_hunt = 1'b1; m_locked = 1'b0;
      end else if (m_hunt) begin
        if (e) begin m_hunt = 1'b0; m_start = cyc; end
      end else begin
        k = (cyc - m_start) % FL;
        if (k != 0 && e) begin
          m_err = 1'b1; m_locked = 1'b0; m_start = cyc;
        end else if (k == 0 && !s) begin
          m_err = 1'b1; m_locked = 1'b0; m_hunt = 1'b1;
        end else if (k == FL - 1) begin
          sum = 0;
          for (int j = cyc - (FL - 1); j <= cyc; j++) sum += int'(s_hist[j]);
          m_out = W'(sum - 1); m_valid = 1'b1; m_locked = 1'b1;
        end
      end
      m_pd = s;
      for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = pwm_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    obs[cyc] = {valid, err, locked, out};
    check("outputs_vs_model", {21'b0, valid, err, locked, out},
          {21'b0, m_valid, m_err, m_locked, m_out});
    check("valid_err_exclusive", {31'b0, valid & err}, 32'd0);
  endtask

  task automatic run_frame(input int code, input int lo_k = -1, input int lo_len = 0,
                           input int rst_k = -1, input int dis_k = -1, input int dis_len = 0);
    for (int i = 0; i < FL; i++) begin
      pwm_in = (dac_k <= code);
      if (lo_k >= 0 && dac_k >= lo_k && dac_k < lo_k + lo_len) pwm_in = 1'b0;
      rst    = (dac_k == rst_k);
      enable = !(dis_k >= 0 && dac_k >= dis_k && dac_k < dis_k + dis_len);
      step();
      dac_k = (dac_k + 1) % FL;
    end
  endtask

  function automatic int count_bit(input int b, input int a, input int z);
    int n = 0;
    for (int c = a; c <= z; c++) if (obs[c][b] === 1'b1) n++;
    return n;
  endfunction

  task automatic expect_valid_at(input string name, input int c, input int exp_out);
    check({name, "_valid"},  {31'b0, obs[c][10]}, 32'd1);
    check({name, "_out"},    {24'b0, obs[c][7:0]}, exp_out);
    check({name, "_locked"}, {31'b0, obs[c][8]}, 32'd1);
  endtask

  initial begin
    int t0, e0, tG, tN1, tN2, tF, tR, tD, tE;

    tbl[0] = '{0,   8'd0};
    tbl[1] = '{255, 8'd255};
    tbl[2] = '{0,   8'd0};
    tbl[3] = '{1,   8'd1};
    tbl[4] = '{128, 8'd128};
    tbl[5] = '{254, 8'd254};
    tbl[6] = '{77,  8'd77};

    // 1: reset, then idle low input
    rst = 1'b1; enable = 1'b1; pwm_in = 1'b0;
    step(); step();
    check("reset_outputs", {21'b0, valid, err, locked, out}, 32'd0);
    rst = 1'b0;
    repeat (600) step();
    check("idle_valids", count_bit(10, 1, cyc), 0);
    check("idle_errs", count_bit(9, 1, cyc), 0);
    check("idle_locked", {31'b0, locked}, 32'd0);
    check("idle_out", {24'b0, out}, 32'd0);

    // 2: code 100 latency and repeat
    t0 = cyc;
    repeat (4) run_frame(100);
    check("t2_no_valid_early", count_bit(10, t0 + 1, t0 + 257), 0);
    expect_valid_at("t2_first", t0 + 258, 100);
    expect_valid_at("t2_second", t0 + 514, 100);
    expect_valid_at("t2_third", t0 + 770, 100);
    check("t2_no_err", count_bit(9, t0 + 1, cyc), 0);

    // 3: table of codes on consecutive frames, including the extremes
    e0 = count_bit(9, 1, cyc);
    t0 = cyc;
    for (int i = 0; i < 7; i++) begin
      fs[i] = cyc;
      run_frame(tbl[i].code);
    end
    run_frame(100);
    for (int i = 0; i < 7; i++)
      expect_valid_at($sformatf("t3_code%0d", tbl[i].code), fs[i] + 258, tbl[i].exp_out);
    check("t3_no_err", count_bit(9, 1, cyc), e0);
    check("t3_lock_held", count_bit(8, t0 + 1, cyc), cyc - t0);

    // 4: extra edge at k=23 in a code-100 frame
    tG = cyc;
    run_frame(100, 20, 3);
    tN1 = cyc;
    run_frame(100);
    tN2 = cyc;
    run_frame(100);
    check("t4_err_glitch", {31'b0, obs[tG + 26][9]}, 32'd1);
    check("t4_lock_lost", {31'b0, obs[tG + 26][8]}, 32'd0);
    check("t4_err_true_edge", {31'b0, obs[tN1 + 3][9]}, 32'd1);
    check("t4_err_count", count_bit(9, tG + 3, cyc), 2);
    check("t4_no_valid", count_bit(10, tG + 5, tN2 + 1), 0);
    expect_valid_at("t4_recover", tN2 + 2, 100);

    // 5: reset at k=128 of a code-50 frame
    run_frame(50); run_frame(50);
    tF = cyc;
    tR = tF + 128;
    run_frame(50, -1, 0, 128);
    check("t5_after_reset", {21'b0, obs[tR + 1]}, 32'd0);
    tE = cyc;
    run_frame(50); run_frame(50);
    check("t5_no_valid_before", count_bit(10, tR + 1, tE + 257), 0);
    expect_valid_at("t5_first", tE + 258, 50);

    // 6: enable dropped for 10 cycles mid-frame at code 77
    run_frame(77); run_frame(77);
    tD = cyc;
    run_frame(77, -1, 0, -1, 100, 10);
    tE = cyc;
    run_frame(77); run_frame(77);
    check("t6_unlocked", {31'b0, obs[tD + 105][8]}, 32'd0);
    check("t6_out_held", {24'b0, obs[tD + 105][7:0]}, 32'd77);
    check("t6_no_err", count_bit(9, tD + 3, cyc), 0);
    check("t6_no_valid", count_bit(10, tD + 5, tE + 257), 0);
    expect_valid_at("t6_resume", tE + 258, 77);

    // Randomized frames with occasional glitches, disables and resets.
    for (int f = 0; f < 30; f++) begin
      int code, lk, ll, rk, dk, dl;
      code = $urandom_range(0, FL - 1);
      lk = -1; ll = 0; rk = -1; dk = -1; dl = 0;
      if ($urandom_range(0, 5) == 0) begin
        lk = $urandom_range(1, 250); ll = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 7) == 0) begin
        dk = $urandom_range(0, 240); dl = $urandom_range(1, 15);
      end
      if ($urandom_range(0, 15) == 0) rk = $urandom_range(0, FL - 1);
      run_frame(code, lk, ll, rk, dk, dl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/pwm_adc.md
Name: pwm_adc

Overview:
- Receive-side counterpart of the team's PWM DAC: recovers the 8-bit code from the 1-bit PWM stream.
- The DAC frame is 2^WIDTH clocks. Within a frame, the output is high while the frame counter is <= code, so there are code+1 high cycles.
- Sample k=0 of every frame is therefore always high.
- The block aligns to frames on rising edges and counts high samples per frame. It outputs code = highs-1 with a one-cycle valid strobe.
- It sits at the board input next to the DAC, or on loop-back for self-test.

Parameters:
- WIDTH, 8, code width; frame length = 2^WIDTH clocks.
- SYNC_STAGES, 2, synchroniser flops on pwm_in; legal range 1..3.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  1 = measure; 0 = force HUNT, hold out.
- pwm_in  input  1  PWM stream, may be asynchronous.
- out  output  WIDTH  last decoded code.
- valid  output  1  one-cycle pulse when out updates.
- locked  output  1  frame alignment confirmed.
- err  output  1  one-cycle pulse on framing error.

Behaviour:
- Reset, on a clk edge with rst=1:
  - synchroniser flops, pwm_d, phase, hi_cnt, out, valid, locked and err all go to 0;
  - state goes to HUNT;
  - rst has priority over enable and pwm_in;
  - reset mid-frame discards the partial frame.
- Input path:
  - pwm_s = pwm_in delayed by SYNC_STAGES flops;
  - pwm_d = pwm_s delayed one more cycle;
  - edge = pwm_s & ~pwm_d.
- Counters:
  - phase: WIDTH bits, sample index k in the frame;
  - hi_cnt: WIDTH+1 bits, range 0..2^WIDTH, no overflow possible.
- HUNT state:
  - valid=0, locked=0;
  - on edge, the edge cycle is k=0: go to MEASURE with phase=1 and hi_cnt=1.
- MEASURE state, every cycle:
  - if phase != 0 and edge: framing error.
    - err=1 for one cycle, locked<=0, out unchanged, no valid.
    - Re-align: this cycle becomes k=0, phase<=1, hi_cnt<=1, stay in MEASURE.
  - if phase == 0 and pwm_s == 0: framing error.
    - err=1, locked<=0, go to HUNT.
  - if phase == 0 and pwm_s == 1: new frame starts; hi_cnt<=1, phase<=1.
  - otherwise: hi_cnt += pwm_s, phase += 1.
  - at phase == 2^WIDTH-1, compute total = hi_cnt + pwm_s; on the next clock:
    - out <= total-1 (truncated to WIDTH);
    - valid <= 1;
    - locked <= 1.
  - phase then wraps to 0.
- Latency:
  - valid is high during the k=0 cycle of the following frame;
  - that is 2^WIDTH cycles after the aligning edge was seen on pwm_s;
  - that is 2^WIDTH+SYNC_STAGES cycles after pwm_in rose.
- Boundary cases:
  - code 0: high 1 sample, total 1, out 0.
  - code 2^WIDTH-1: always high, no further edges after the first. The free-running phase keeps alignment; lock is held and out = 2^WIDTH-1 each frame.
  - An edge at phase==0 is a normal frame start.
  - err and valid are never high in the same cycle.
- enable=0:
  - next state HUNT, locked<=0, phase and hi_cnt cleared;
  - out holds, no valid or err;
  - sync flops keep running.
- Only the first frame completed after alignment sets locked; there is no multi-frame confirmation.

Test Plan:
1. rst, then pwm_in=0 for 600 cycles -> state HUNT; valid, err, locked and out stay 0.
2. DAC model at code 100 starts at cycle t0 (pwm_in rises t0), SYNC_STAGES=2, runs 3 frames:
   - first valid at t0+258 with out=100, locked=1;
   - further valids at t0+514 and t0+770, out=100.
3. Codes 0, then 255, then 0 on consecutive frames -> valids with out=0, 255, 0.
   - During 255, no edge and no err; locked stays 1.
4. Code 100 locked; force pwm_in low for 3 cycles at k=20, then high for 2 more cycles, giving an extra edge at k=23:
   - err pulse at edge detection, locked=0, no valid that frame;
   - the true frame edge raises err again and re-aligns;
   - next valid 256 cycles later, out=100, locked=1.
5. rst asserted for 1 cycle at k=128 of a code-50 frame -> next cycle all outputs 0, HUNT.
   - First valid comes 2^WIDTH+SYNC_STAGES cycles after the next pwm_in rise, out=50.
6. enable dropped for 10 cycles mid-frame at code 77 -> locked=0, out holds 77.
   - After re-enable, the next valid shows 77.
